// File: rtl/mdr_pkg.sv
// Shared definitions for the memory data register: access sizes, FSM states,
// and the lane-mask / alignment / extension helpers used by the datapath.
package mdr_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE,
    S_ERR
  } state_t;

  // Helpers work on the widest (64-bit, 8-lane) case; callers cast down.
  function automatic logic [7:0] lane_mask(input logic [1:0] sz, input logic [2:0] a);
    logic [7:0] m;
    case (sz)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << a;
  endfunction

  function automatic logic [2:0] lane_span(input logic [1:0] sz);
    logic [2:0] s;
    case (sz)
      SZ_B:    s = 3'd0;
      SZ_H:    s = 3'd1;
      SZ_W:    s = 3'd3;
      default: s = 3'd7;
    endcase
    return s;
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] a);
    logic m;
    case (sz)
      SZ_B:    m = 1'b0;
      SZ_H:    m = a[0];
      SZ_W:    m = |a[1:0];
      default: m = |a;
    endcase
    return m;
  endfunction

  function automatic logic [63:0] extend(input logic [63:0] d, input logic [1:0] sz,
                                         input logic sx);
    logic [63:0] r;
    case (sz)
      SZ_B:    r = {{56{sx & d[7]}}, d[7:0]};
      SZ_H:    r = {{48{sx & d[15]}}, d[15:0]};
      SZ_W:    r = {{32{sx & d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mdr_lane_align.sv
// Combinational lane steering: byte enables and replicated write data for a
// request, and shift/extend of returning read data.
module mdr_lane_align
  import mdr_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int AW     = $clog2(NB)
) (
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [AW-1:0]     addr_lo,
  input  logic [DATA_W-1:0] mdr,
  input  logic [DATA_W-1:0] rdata,
  output logic [NB-1:0]     be,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rext
);

  assign be   = NB'(lane_mask(size, 3'(addr_lo)));
  assign rext = DATA_W'(extend(64'(rdata >> {addr_lo, 3'b000}), size, sext));

  // Each lane carries the byte of the low operand that it lines up with,
  // so whichever lanes are enabled see the operand in its natural position.
  always_comb begin
    wdata = '0;
    for (int i = 0; i < NB; i++)
      wdata[8*i +: 8] = mdr[8*(i & int'(lane_span(size))) +: 8];
  end

endmodule

// File: rtl/mdr_mem_if.sv
// Memory data register with bus load, sized memory reads/writes over a
// req/ack port with timeout, and one-cycle done/err status pulses.
module mdr_mem_if
  import mdr_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int TIMEOUT = 16,
  localparam int NB      = DATA_W / 8,
  localparam int AW      = $clog2(NB)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [AW-1:0]     addr_lo,
  output logic              mem_req,
  output logic              mem_we,
  output logic [NB-1:0]     mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] MdataIn,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] MDROut,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  state_t            state;
  logic [1:0]        lat_size;
  logic              lat_sext;
  logic [AW-1:0]     lat_addr;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_inc;
  logic [1:0]        sel_size;
  logic              sel_sext;
  logic [AW-1:0]     sel_addr;
  logic [NB-1:0]     be_n;
  logic [DATA_W-1:0] wdata_n;
  logic [DATA_W-1:0] rext_n;
  logic              illegal;

  // Live sideband drives the aligner while idle; the latched copy once accepted.
  assign sel_size = (state == S_IDLE) ? size    : lat_size;
  assign sel_sext = (state == S_IDLE) ? sext    : lat_sext;
  assign sel_addr = (state == S_IDLE) ? addr_lo : lat_addr;
  assign cnt_inc  = cnt + CW'(1);

  assign illegal = (Read && Write)
                || (size == SZ_D && DATA_W == 32)
                || misaligned(size, 3'(addr_lo));

  mdr_lane_align #(.DATA_W(DATA_W)) u_align (
    .size    (sel_size),
    .sext    (sel_sext),
    .addr_lo (sel_addr),
    .mdr     (MDROut),
    .rdata   (MdataIn),
    .be      (be_n),
    .wdata   (wdata_n),
    .rext    (rext_n)
  );

  // An ack in the same cycle the counter hits TIMEOUT is checked first and wins.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= S_IDLE;
      MDROut    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cnt       <= '0;
      lat_size  <= SZ_B;
      lat_sext  <= 1'b0;
      lat_addr  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Read || Write) begin
            lat_size <= size;
            lat_sext <= sext;
            lat_addr <= addr_lo;
            cnt      <= '0;
            busy     <= 1'b1;
            if (illegal) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else begin
              state     <= S_REQ;
              mem_req   <= 1'b1;
              mem_we    <= Write;
              mem_be    <= be_n;
              mem_wdata <= wdata_n;
            end
          end else if (MDRin) begin
            MDROut <= BusMuxOut;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            if (!mem_we)
              MDROut <= rext_n;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_be  <= '0;
            done    <= 1'b1;
            state   <= S_DONE;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == TMAX) begin
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
              mem_be  <= '0;
              err     <= 1'b1;
              state   <= S_ERR;
            end
          end
        end
        S_DONE, S_ERR: begin
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
